// File: rtl/vdp_pkg.sv
// Shared VDP definitions: access codes, address widths and the CPU-port fetch FSM states.
package vdp_pkg;

    localparam int unsigned VRAM_AW = 14;
    localparam int unsigned PAL_AW  = 5;

    localparam logic [1:0] CODE_VRD  = 2'd0;
    localparam logic [1:0] CODE_VWR  = 2'd1;
    localparam logic [1:0] CODE_REG  = 2'd2;
    localparam logic [1:0] CODE_CRAM = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/vdp_cpu_port_if.sv
// CPU, VRAM, palette and register-file signals seen by the VDP CPU port.
interface vdp_cpu_port_if #(
    parameter int unsigned VRAM_AW = vdp_pkg::VRAM_AW,
    parameter int unsigned PAL_AW  = vdp_pkg::PAL_AW
);
    logic               io_sel;
    logic               io_rden;
    logic               io_wren;
    logic [7:0]         io_wrdata;
    logic [7:0]         io_rddata;
    logic [7:0]         stat;
    logic               stat_rd;
    logic [VRAM_AW-1:0] vram_addr;
    logic [7:0]         vram_wrdata;
    logic               vram_wren;
    logic               vram_rden;
    logic [7:0]         vram_rddata;
    logic [PAL_AW-1:0]  pal_addr;
    logic [7:0]         pal_wrdata;
    logic               pal_wren;
    logic [3:0]         reg_idx;
    logic [7:0]         reg_data;
    logic               reg_wren;

    modport slave (
        input  io_sel, io_rden, io_wren, io_wrdata, stat, vram_rddata,
        output io_rddata, stat_rd, vram_addr, vram_wrdata, vram_wren, vram_rden,
        output pal_addr, pal_wrdata, pal_wren, reg_idx, reg_data, reg_wren
    );

    modport master (
        output io_sel, io_rden, io_wren, io_wrdata, stat, vram_rddata,
        input  io_rddata, stat_rd, vram_addr, vram_wrdata, vram_wren, vram_rden,
        input  pal_addr, pal_wrdata, pal_wren, reg_idx, reg_data, reg_wren
    );
endinterface

// File: rtl/vdp_cpu_port.sv
// VDP CPU front end: control latch, auto-incrementing access address,
// VRAM read-ahead buffer and palette/register write decode.
module vdp_cpu_port #(
    parameter int unsigned VRAM_AW = vdp_pkg::VRAM_AW,
    parameter int unsigned PAL_AW  = vdp_pkg::PAL_AW
) (
    input  logic             clk,
    input  logic             reset,
    vdp_cpu_port_if.slave    bus
);
    import vdp_pkg::*;

    fetch_state_e       state_q, state_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic [1:0]         code_q, code_d;
    logic               first_byte_q, first_byte_d;
    logic [7:0]         lo_latch_q, lo_latch_d;
    logic [7:0]         rdbuf_q, rdbuf_d;
    logic               pend_q, pend_d;
    logic [7:0]         pend_data_q, pend_data_d;

    logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
    logic [7:0]         vram_wrdata_q, vram_wrdata_d;
    logic               vram_wren_q, vram_wren_d;
    logic               vram_rden_q, vram_rden_d;
    logic [PAL_AW-1:0]  pal_addr_q, pal_addr_d;
    logic [7:0]         pal_wrdata_q, pal_wrdata_d;
    logic               pal_wren_q, pal_wren_d;
    logic [3:0]         reg_idx_q, reg_idx_d;
    logic [7:0]         reg_data_q, reg_data_d;
    logic               reg_wren_q, reg_wren_d;
    logic               stat_rd_q, stat_rd_d;

    logic               ctl_wr, ctl_rd, dat_wr, dat_rd, busy;
    logic               wr_go, fetch_go;
    logic [7:0]         wr_data;
    logic [VRAM_AW-1:0] fetch_at, new_addr;

    // A write with a simultaneous read suppresses every side effect of the read.
    assign ctl_wr = bus.io_wren &  bus.io_sel;
    assign dat_wr = bus.io_wren & ~bus.io_sel;
    assign ctl_rd = bus.io_rden & ~bus.io_wren &  bus.io_sel;
    assign dat_rd = bus.io_rden & ~bus.io_wren & ~bus.io_sel;
    assign busy   = (state_q != ST_IDLE);

    assign new_addr = VRAM_AW'({bus.io_wrdata[5:0], lo_latch_q});

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        code_d        = code_q;
        first_byte_d  = first_byte_q;
        lo_latch_d    = lo_latch_q;
        rdbuf_d       = rdbuf_q;
        pend_d        = pend_q;
        pend_data_d   = pend_data_q;
        vram_addr_d   = vram_addr_q;
        vram_wrdata_d = vram_wrdata_q;
        vram_wren_d   = 1'b0;
        vram_rden_d   = 1'b0;
        pal_addr_d    = pal_addr_q;
        pal_wrdata_d  = pal_wrdata_q;
        pal_wren_d    = 1'b0;
        reg_idx_d     = reg_idx_q;
        reg_data_d    = reg_data_q;
        reg_wren_d    = 1'b0;
        stat_rd_d     = 1'b0;
        wr_go         = 1'b0;
        wr_data       = bus.io_wrdata;
        fetch_go      = 1'b0;
        fetch_at      = addr_q;

        // Data writes landing during a fetch are parked until the VRAM port is free.
        if (dat_wr && busy) begin
            pend_d      = 1'b1;
            pend_data_d = bus.io_wrdata;
        end else if (dat_wr) begin
            wr_go = 1'b1;
        end else if (pend_q && !busy) begin
            wr_go   = 1'b1;
            wr_data = pend_data_q;
            pend_d  = 1'b0;
        end

        if (ctl_wr) begin
            if (!first_byte_q) begin
                lo_latch_d   = bus.io_wrdata;
                addr_d       = {addr_q[VRAM_AW-1:8], bus.io_wrdata};
                first_byte_d = 1'b1;
            end else begin
                code_d       = bus.io_wrdata[7:6];
                addr_d       = new_addr;
                first_byte_d = 1'b0;
                if (bus.io_wrdata[7:6] == CODE_VRD) begin
                    fetch_go = 1'b1;
                    fetch_at = new_addr;
                    addr_d   = new_addr + VRAM_AW'(1);
                end
                if (bus.io_wrdata[7:6] == CODE_REG) begin
                    reg_wren_d = 1'b1;
                    reg_idx_d  = bus.io_wrdata[3:0];
                    reg_data_d = lo_latch_q;
                end
            end
        end else if (ctl_rd) begin
            stat_rd_d    = 1'b1;
            first_byte_d = 1'b0;
        end else if (dat_rd) begin
            first_byte_d = 1'b0;
            fetch_go     = 1'b1;
            fetch_at     = addr_q;
            addr_d       = addr_q + VRAM_AW'(1);
        end else if (dat_wr) begin
            first_byte_d = 1'b0;
        end

        if (wr_go) begin
            rdbuf_d = wr_data;
            addr_d  = addr_q + VRAM_AW'(1);
            if (code_q == CODE_CRAM) begin
                pal_wren_d   = 1'b1;
                pal_addr_d   = addr_q[PAL_AW-1:0];
                pal_wrdata_d = wr_data;
            end else begin
                vram_wren_d   = 1'b1;
                vram_addr_d   = addr_q;
                vram_wrdata_d = wr_data;
            end
        end

        // FETCH spans the request cycle (vram_rden high) and the latch cycle.
        case (state_q)
            ST_IDLE: begin
                if (fetch_go && !wr_go) begin
                    state_d     = ST_FETCH;
                    vram_rden_d = 1'b1;
                    vram_addr_d = fetch_at;
                end
            end
            ST_FETCH: begin
                if (!vram_rden_q) begin
                    rdbuf_d = bus.vram_rddata;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            code_q        <= '0;
            first_byte_q  <= 1'b0;
            lo_latch_q    <= '0;
            rdbuf_q       <= '0;
            pend_q        <= 1'b0;
            pend_data_q   <= '0;
            vram_addr_q   <= '0;
            vram_wrdata_q <= '0;
            vram_wren_q   <= 1'b0;
            vram_rden_q   <= 1'b0;
            pal_addr_q    <= '0;
            pal_wrdata_q  <= '0;
            pal_wren_q    <= 1'b0;
            reg_idx_q     <= '0;
            reg_data_q    <= '0;
            reg_wren_q    <= 1'b0;
            stat_rd_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            code_q        <= code_d;
            first_byte_q  <= first_byte_d;
            lo_latch_q    <= lo_latch_d;
            rdbuf_q       <= rdbuf_d;
            pend_q        <= pend_d;
            pend_data_q   <= pend_data_d;
            vram_addr_q   <= vram_addr_d;
            vram_wrdata_q <= vram_wrdata_d;
            vram_wren_q   <= vram_wren_d;
            vram_rden_q   <= vram_rden_d;
            pal_addr_q    <= pal_addr_d;
            pal_wrdata_q  <= pal_wrdata_d;
            pal_wren_q    <= pal_wren_d;
            reg_idx_q     <= reg_idx_d;
            reg_data_q    <= reg_data_d;
            reg_wren_q    <= reg_wren_d;
            stat_rd_q     <= stat_rd_d;
        end
    end

    assign bus.io_rddata   = bus.io_sel ? bus.stat : rdbuf_q;
    assign bus.stat_rd     = stat_rd_q;
    assign bus.vram_addr   = vram_addr_q;
    assign bus.vram_wrdata = vram_wrdata_q;
    assign bus.vram_wren   = vram_wren_q;
    assign bus.vram_rden   = vram_rden_q;
    assign bus.pal_addr    = pal_addr_q;
    assign bus.pal_wrdata  = pal_wrdata_q;
    assign bus.pal_wren    = pal_wren_q;
    assign bus.reg_idx     = reg_idx_q;
    assign bus.reg_data    = reg_data_q;
    assign bus.reg_wren    = reg_wren_q;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Scoreboard bench for vdp_cpu_port: expected strobe events queued at stimulus time,
// compared in order as the port emits them.
module tb_vdp_cpu_port;
    import vdp_pkg::*;

    localparam logic [3:0] EV_VWR  = 4'd1;
    localparam logic [3:0] EV_VRD  = 4'd2;
    localparam logic [3:0] EV_PAL  = 4'd3;
    localparam logic [3:0] EV_REG  = 4'd4;
    localparam logic [3:0] EV_STAT = 4'd5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vdp_cpu_port_if bus ();

    vdp_cpu_port dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  vmem [0:(2**VRAM_AW)-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic [3:0] k, input logic [13:0] a, input logic [7:0] d);
        return {6'd0, k, a, d};
    endfunction

    task automatic sb_pop(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) check({tag, "_unexpected"}, obs, 32'hFFFF_FFFF);
        else                   check(tag, obs, exp_q.pop_front());
    endtask

    // Synchronous VRAM model with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.vram_wren) vmem[bus.vram_addr] <= bus.vram_wrdata;
        if (bus.vram_rden) bus.vram_rddata <= vmem[bus.vram_addr];
    end

    always @(negedge clk) begin
        if (bus.vram_wren || bus.vram_rden)
            check("vram_excl", 32'(bus.vram_wren & bus.vram_rden), 32'd0);
        if (bus.vram_wren) sb_pop("vram_wr", ev(EV_VWR, bus.vram_addr, bus.vram_wrdata));
        if (bus.vram_rden) sb_pop("vram_rd", ev(EV_VRD, bus.vram_addr, 8'h00));
        if (bus.pal_wren)  sb_pop("pal_wr",  ev(EV_PAL, 14'(bus.pal_addr), bus.pal_wrdata));
        if (bus.reg_wren)  sb_pop("reg_wr",  ev(EV_REG, 14'(bus.reg_idx), bus.reg_data));
        if (bus.stat_rd)   sb_pop("stat_rd", ev(EV_STAT, 14'd0, 8'h00));
    end

    task automatic wr(input logic sel, input logic [7:0] d);
        bus.io_sel    = sel;
        bus.io_wrdata = d;
        bus.io_wren   = 1'b1;
        @(posedge clk); #1;
        bus.io_wren = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic sel, input logic [7:0] exp, input string tag);
        bus.io_sel  = sel;
        bus.io_rden = 1'b1;
        #1;
        check(tag, 32'(bus.io_rddata), 32'(exp));
        @(posedge clk); #1;
        bus.io_rden = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_strobes"}, 32'({bus.vram_wren, bus.vram_rden, bus.pal_wren, bus.reg_wren, bus.stat_rd}), 32'd0);
        check({tag, "_vram"}, {10'd0, bus.vram_addr, bus.vram_wrdata}, 32'd0);
        check({tag, "_pal"}, {19'd0, bus.pal_addr, bus.pal_wrdata}, 32'd0);
        check({tag, "_reg"}, {20'd0, bus.reg_idx, bus.reg_data}, 32'd0);
        bus.io_sel = 1'b0;
        #1;
        check({tag, "_rdbuf"}, 32'(bus.io_rddata), 32'd0);
    endtask

    initial begin
        bus.io_sel    = 1'b0;
        bus.io_rden   = 1'b0;
        bus.io_wren   = 1'b0;
        bus.io_wrdata = 8'h00;
        bus.stat      = 8'h5A;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Palette writes from address 0.
        exp_q.push_back(ev(EV_PAL, 14'd0, 8'h3F));
        exp_q.push_back(ev(EV_PAL, 14'd1, 8'h0C));
        wr(1'b1, 8'h00); wr(1'b1, 8'hC0); wr(1'b0, 8'h3F); wr(1'b0, 8'h0C);

        // Palette address wraps 31 -> 0 while the VRAM address keeps counting.
        exp_q.push_back(ev(EV_PAL, 14'd31, 8'h11));
        exp_q.push_back(ev(EV_PAL, 14'd0,  8'h22));
        wr(1'b1, 8'h1F); wr(1'b1, 8'hC0); wr(1'b0, 8'h11); wr(1'b0, 8'h22);
        check("addr_after_wrap", 32'(dut.addr_q), 32'h0000_0021);

        // Register write: index from second byte, data from first byte.
        exp_q.push_back(ev(EV_REG, 14'd7, 8'h81));
        wr(1'b1, 8'h81); wr(1'b1, 8'h87);

        // Preload VRAM, then read back through the read-ahead buffer.
        exp_q.push_back(ev(EV_VWR, 14'h1234, 8'hAA));
        exp_q.push_back(ev(EV_VWR, 14'h1235, 8'hBB));
        wr(1'b1, 8'h34); wr(1'b1, 8'h52); wr(1'b0, 8'hAA); wr(1'b0, 8'hBB);
        exp_q.push_back(ev(EV_VRD, 14'h1234, 8'h00));
        wr(1'b1, 8'h34); wr(1'b1, 8'h12);
        exp_q.push_back(ev(EV_VRD, 14'h1235, 8'h00));
        rd(1'b0, 8'hAA, "data_rd1");
        exp_q.push_back(ev(EV_VRD, 14'h1236, 8'h00));
        rd(1'b0, 8'hBB, "data_rd2");

        // Control read returns status and resets the byte phase.
        bus.stat = 8'hC3;
        wr(1'b1, 8'h55);
        exp_q.push_back(ev(EV_STAT, 14'd0, 8'h00));
        rd(1'b1, 8'hC3, "ctl_rd_stat");
        exp_q.push_back(ev(EV_VWR, 14'h0000, 8'h77));
        wr(1'b1, 8'h00); wr(1'b1, 8'h40); wr(1'b0, 8'h77);

        // Reset lands during the fetch request cycle.
        exp_q.push_back(ev(EV_VWR, 14'h0000, 8'h99));
        wr(1'b1, 8'h00); wr(1'b1, 8'h40); wr(1'b0, 8'h99);
        exp_q.push_back(ev(EV_VRD, 14'h0001, 8'h00));
        bus.io_sel  = 1'b0;
        bus.io_rden = 1'b1;
        #1;
        check("rd_before_rst", 32'(bus.io_rddata), 32'h99);
        @(posedge clk); #1;
        bus.io_rden = 1'b0;
        reset       = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("mid_fetch_rst");
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Simultaneous read and write: only the write takes effect.
        wr(1'b1, 8'h10); wr(1'b1, 8'h40);
        exp_q.push_back(ev(EV_VWR, 14'h0010, 8'h66));
        bus.io_sel    = 1'b0;
        bus.io_wrdata = 8'h66;
        bus.io_wren   = 1'b1;
        bus.io_rden   = 1'b1;
        #1;
        check("rdwr_rddata", 32'(bus.io_rddata), 32'h00);
        @(posedge clk); #1;
        bus.io_wren = 1'b0;
        bus.io_rden = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rdwr_rdbuf", 32'(bus.io_rddata), 32'h66);
        check("addr_after_rdwr", 32'(dut.addr_q), 32'h0000_0011);

        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
